// File: rtl/mode_switch_ctrl.sv
// Front-panel mode selector: synchronises and debounces a thermometer-coded switch
// bank, maps the settled level to a mode code and active-low one-hot LEDs.
module mode_switch_ctrl #(
    parameter int SW_W = 16,
    parameter int LED_W = 16,
    parameter int N_LEVELS = 5,
    parameter int MODE_W = 4,
    parameter logic [(N_LEVELS+1)*MODE_W-1:0] MODE_MAP = 24'h354210,
    parameter int DEBOUNCE_CYC = 4,
    parameter int FRAME_SYNC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   Switch,
    input  logic              frame_start,
    output logic [LED_W-1:0]  Led,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              pending
);

    localparam int SYNC_W = N_LEVELS + 1;
    localparam int LVL_W = $clog2(N_LEVELS + 1);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

    state_t            state;
    logic [SYNC_W-1:0] sync1, sync2;
    logic [LVL_W-1:0]  decoded, cand, committed;
    logic [CNT_W-1:0]  cnt;
    logic              accepted;
    logic [MODE_W-1:0] cand_mode;
    logic [LED_W-1:0]  cand_led;

    generate
        if (SW_W > SYNC_W) begin : g_unused
            logic unused_sw;
            assign unused_sw = ^Switch[SW_W-1:SYNC_W];
        end
    endgenerate

    // Any non-thermometer pattern (including all-zero) falls through to level 0.
    always_comb begin
        decoded = '0;
        for (int unsigned k = 1; k <= N_LEVELS; k++) begin
            if (sync2 == ((SYNC_W'(1) << k) - SYNC_W'(1)))
                decoded = LVL_W'(k);
        end
    end

    always_comb begin
        cand_mode = '0;
        cand_led  = '1;
        for (int unsigned k = 0; k <= N_LEVELS; k++) begin
            if (cand == LVL_W'(k))
                cand_mode = MODE_MAP[k*MODE_W +: MODE_W];
        end
        for (int unsigned i = 0; i < N_LEVELS; i++) begin
            if (cand == LVL_W'(i + 1))
                cand_led[i] = 1'b0;
        end
    end

    assign accepted = (decoded == cand) && (cnt == CNT_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            cnt       <= '0;
            committed <= '0;
            state     <= IDLE;
            Led       <= '1;
            mode      <= '0;
            mode_chg  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            sync1    <= Switch[N_LEVELS:0];
            sync2    <= sync1;
            mode_chg <= 1'b0;

            if (decoded != cand) begin
                cand <= decoded;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (decoded != committed)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (accepted) begin
                        if (cand == committed) begin
                            state <= IDLE;
                        end else if (FRAME_SYNC == 0 || frame_start) begin
                            mode      <= cand_mode;
                            Led       <= cand_led;
                            committed <= cand;
                            mode_chg  <= (cand_mode != mode);
                            state     <= IDLE;
                        end else begin
                            pending <= 1'b1;
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A changed input cancels the deferred commit even on a frame boundary.
                    if (decoded != cand) begin
                        pending <= 1'b0;
                        state   <= SETTLE;
                    end else if (frame_start) begin
                        mode      <= cand_mode;
                        Led       <= cand_led;
                        committed <= cand;
                        mode_chg  <= (cand_mode != mode);
                        pending   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Bench for mode_switch_ctrl: immediate-commit and frame-synchronised instances
// driven in lockstep and compared each cycle against a run-length reference model.
module tb_mode_switch_ctrl;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Switch;
    logic        frame_start;
    logic [15:0] led0, led1;
    logic [3:0]  mode0, mode1;
    logic        chg0, chg1, pend0, pend1;

    mode_switch_ctrl #(.DEBOUNCE_CYC(DC), .FRAME_SYNC(0)) u0 (
        .clk(clk), .rst_n(rst_n), .Switch(Switch), .frame_start(frame_start),
        .Led(led0), .mode(mode0), .mode_chg(chg0), .pending(pend0)
    );

    mode_switch_ctrl #(.DEBOUNCE_CYC(DC), .FRAME_SYNC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .Switch(Switch), .frame_start(frame_start),
        .Led(led1), .mode(mode1), .mode_chg(chg1), .pending(pend1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses0 = 0;
    int map_tab[6] = '{0, 1, 2, 4, 5, 3};

    // Reference state per instance: input pipeline, current run, committed level, deferral.
    int p1[2], p2[2], runv[2], runl[2], com[2], pval[2];
    bit pend[2], echg[2];

    function automatic int lvl(input logic [15:0] sw);
        int v;
        v = int'(sw[5:0]);
        for (int k = 1; k <= 5; k++)
            if (v == (1 << k) - 1) return k;
        return 0;
    endfunction

    function automatic logic [15:0] exp_led(input int k);
        return (k == 0) ? 16'hffff : ~(16'h0001 << (k - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            p1[i] = 0; p2[i] = 0; runv[i] = 0; runl[i] = 1;
            com[i] = 0; pval[i] = 0; pend[i] = 0; echg[i] = 0;
        end
    endtask

    task automatic model_commit(input int i, input int v);
        echg[i] = (map_tab[v] != map_tab[com[i]]);
        com[i]  = v;
        pend[i] = 0;
    endtask

    task automatic model_edge();
        int d;
        bit fs;
        for (int i = 0; i < 2; i++) begin
            d = p2[i];
            p2[i] = p1[i];
            p1[i] = lvl(Switch);
            fs = (i == 0) ? 1'b1 : frame_start;
            if (d == runv[i]) runl[i]++;
            else begin runv[i] = d; runl[i] = 1; end
            echg[i] = 0;
            if (pend[i]) begin
                if (d != pval[i]) pend[i] = 0;
                else if (fs) model_commit(i, pval[i]);
            end else if (runl[i] == DC + 1 && d != com[i]) begin
                if (fs) model_commit(i, d);
                else begin pend[i] = 1; pval[i] = d; end
            end
        end
    endtask

    task automatic check_all();
        chk("mode0", {28'h0, mode0}, map_tab[com[0]]);
        chk("led0", {16'h0, led0}, {16'h0, exp_led(com[0])});
        chk("chg0", {31'h0, chg0}, {31'h0, echg[0]});
        chk("pend0", {31'h0, pend0}, 32'h0);
        chk("mode1", {28'h0, mode1}, map_tab[com[1]]);
        chk("led1", {16'h0, led1}, {16'h0, exp_led(com[1])});
        chk("chg1", {31'h0, chg1}, {31'h0, echg[1]});
        chk("pend1", {31'h0, pend1}, {31'h0, pend[1]});
        pulses0 += int'(chg0);
    endtask

    task automatic step(input logic [15:0] sw, input logic f);
        Switch = sw;
        frame_start = f;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input logic [15:0] sw, input logic f, input int n);
        for (int j = 0; j < n; j++) step(sw, f);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_led0", {16'h0, led0}, 32'hffff);
        chk("rst_mode0", {28'h0, mode0}, 32'h0);
        chk("rst_mode1", {28'h0, mode1}, 32'h0);
        chk("rst_pend1", {31'h0, pend1}, 32'h0);
        chk("rst_chg1", {31'h0, chg1}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int hold;
        int r;
        logic [15:0] sw;
        rst_n = 1'b0;
        Switch = '0;
        frame_start = 1'b0;
        model_reset();
        #12;
        chk("por_led1", {16'h0, led1}, 32'hffff);
        chk("por_mode0", {28'h0, mode0}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        steps(16'h0000, 1'b0, 3);
        chk("t1_led0", {16'h0, led0}, 32'hffff);
        chk("t1_chg0", {31'h0, chg0}, 32'h0);

        pulses0 = 0;
        steps(16'h0003, 1'b0, 6);
        chk("t2_early", {28'h0, mode0}, 32'h0);
        step(16'h0003, 1'b0);
        chk("t2_mode", {28'h0, mode0}, 32'h2);
        chk("t2_led", {16'h0, led0}, 32'hfffd);
        chk("t2_pend1", {31'h0, pend1}, 32'h1);
        steps(16'h0003, 1'b0, 2);
        chk("t2_pulses", pulses0, 32'd1);

        steps(16'h001F, 1'b0, 8);
        chk("t3_mode", {28'h0, mode0}, 32'h3);
        chk("t3_led", {16'h0, led0}, 32'hffef);
        steps(16'h003F, 1'b0, 8);
        chk("t3_3f", {28'h0, mode0}, 32'h0);
        steps(16'h0003, 1'b0, 8);
        steps(16'h0005, 1'b0, 8);
        chk("t3_05", {28'h0, mode0}, 32'h0);
        chk("t3_05led", {16'h0, led0}, 32'hffff);

        steps(16'h0003, 1'b1, 8);
        pulses0 = 0;
        steps(16'h0007, 1'b0, 3);
        steps(16'h0003, 1'b0, 8);
        chk("t4_mode", {28'h0, mode0}, 32'h2);
        chk("t4_pulses", pulses0, 32'd0);

        do_reset();
        steps(16'h000F, 1'b0, 7);
        chk("t5_pend", {31'h0, pend1}, 32'h1);
        chk("t5_hold", {28'h0, mode1}, 32'h0);
        steps(16'h000F, 1'b0, 3);
        step(16'h000F, 1'b1);
        chk("t5_mode", {28'h0, mode1}, 32'h5);
        chk("t5_led", {16'h0, led1}, 32'hfff7);
        chk("t5_pend0", {31'h0, pend1}, 32'h0);

        steps(16'h0003, 1'b0, 7);
        chk("t6_pend", {31'h0, pend1}, 32'h1);
        steps(16'h0001, 1'b0, 3);
        chk("t6_cancel", {31'h0, pend1}, 32'h0);
        chk("t6_nocommit", {28'h0, mode1}, 32'h5);
        steps(16'h0001, 1'b0, 4);
        chk("t6_pend2", {31'h0, pend1}, 32'h1);
        do_reset();

        for (int s = 0; s < 80; s++) begin
            if (s == 40) do_reset();
            r = $urandom_range(0, 9);
            if (r < 6) sw = 16'((1 << r) - 1) | (16'($urandom) & 16'hffc0);
            else sw = 16'($urandom);
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++)
                step(sw, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
